// File: rtl/tl_error_slave_q_if.sv
// TileLink-UH A/D channel bundle between a requester and the error slave.
// The slave modport faces the error slave; the master modport faces the requester.
interface tl_error_slave_q_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14,
  parameter int SRC_W  = 3,
  parameter int SIZE_W = 4
);
  localparam int BYTES = DATA_W / 8;

  logic              a_valid;
  logic              a_ready;
  logic [2:0]        a_opcode;
  logic [2:0]        a_param;
  logic [SIZE_W-1:0] a_size;
  logic [SRC_W-1:0]  a_source;
  logic [ADDR_W-1:0] a_address;
  logic [BYTES-1:0]  a_mask;
  logic [DATA_W-1:0] a_data;
  logic              a_corrupt;

  logic              d_valid;
  logic              d_ready;
  logic [2:0]        d_opcode;
  logic [1:0]        d_param;
  logic [SIZE_W-1:0] d_size;
  logic [SRC_W-1:0]  d_source;
  logic              d_sink;
  logic              d_denied;
  logic [DATA_W-1:0] d_data;
  logic              d_corrupt;

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address,
           a_mask, a_data, a_corrupt, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source,
           d_sink, d_denied, d_data, d_corrupt
  );

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address,
           a_mask, a_data, a_corrupt, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source,
           d_sink, d_denied, d_data, d_corrupt
  );
endinterface

// File: rtl/tl_error_slave_q.sv
// TileLink-UH error slave: queues A beats, answers every request with a denied
// D response of the matching opcode and beat count, and logs completed requests.
module tl_error_slave_q #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14,
  parameter int SRC_W  = 3,
  parameter int SIZE_W = 4,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  tl_error_slave_q_if.slave  tl,
  input  logic               err_clear,
  output logic [CNT_W-1:0]   err_count,
  output logic               err_vld,
  output logic [ADDR_W-1:0]  err_addr
);
  localparam int BYTES = DATA_W / 8;
  localparam int LOG_B = $clog2(BYTES);
  localparam int BW    = SIZE_W + 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [2:0]        op;
    logic [SIZE_W-1:0] size;
    logic [SRC_W-1:0]  src;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  typedef enum logic [1:0] {IDLE, DRAIN, RESP} state_t;

  function automatic logic [BW-1:0] beats_of(input logic [SIZE_W-1:0] sz);
    if (sz <= SIZE_W'(LOG_B)) return BW'(1);
    return BW'(1) << (sz - SIZE_W'(LOG_B));
  endfunction

  // Arith, Logic and Get return data for every beat; everything else acks once.
  function automatic logic [BW-1:0] resp_beats(input logic [2:0] op,
                                               input logic [BW-1:0] nb);
    if (op == 3'd2 || op == 3'd3 || op == 3'd4) return nb;
    return BW'(1);
  endfunction

  function automatic logic [2:0] resp_opcode(input logic [2:0] op);
    case (op)
      3'd2, 3'd3, 3'd4: return 3'd1;
      3'd5:             return 3'd2;
      default:          return 3'd0;
    endcase
  endfunction

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    if (DEPTH == 1) return '0;
    if (p == AW'(DEPTH - 1)) return '0;
    return p + AW'(1);
  endfunction

  entry_t            mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     fill_q, fill_d;
  state_t            state_q, state_d;
  entry_t            hdr_q, hdr_d;
  logic [BW-1:0]     beats_q, beats_d;
  logic [BW-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic              err_vld_q, err_vld_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic   full, empty, push, pop, done;
  entry_t entry_in, head;
  logic [BW-1:0] head_beats;
  logic   unused_ok;

  assign unused_ok = ^{tl.a_param, tl.a_mask, tl.a_data, tl.a_corrupt};

  assign full       = (fill_q == CW'(DEPTH));
  assign empty      = (fill_q == '0);
  assign push       = tl.a_valid && !full;
  assign head       = mem_q[rd_ptr_q];
  assign head_beats = beats_of(head.size);
  assign entry_in   = '{op: tl.a_opcode, size: tl.a_size,
                        src: tl.a_source, addr: tl.a_address};

  always_comb begin
    wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    fill_d   = fill_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + CW'(1);
      2'b01:   fill_d = fill_q - CW'(1);
      default: fill_d = fill_q;
    endcase
  end

  // cnt_q counts remaining drain pops in DRAIN and remaining D beats in RESP.
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    beats_d = beats_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          hdr_d   = head;
          beats_d = head_beats;
          if (head.op <= 3'd3 && head_beats > BW'(1)) begin
            cnt_d   = head_beats - BW'(1);
            state_d = DRAIN;
          end else begin
            cnt_d   = resp_beats(head.op, head_beats);
            state_d = RESP;
          end
        end
      end
      DRAIN: begin
        if (!empty) begin
          pop = 1'b1;
          if (cnt_q == BW'(1)) begin
            cnt_d   = resp_beats(hdr_q.op, beats_q);
            state_d = RESP;
          end else begin
            cnt_d = cnt_q - BW'(1);
          end
        end
      end
      RESP: begin
        if (tl.d_ready) begin
          if (cnt_q == BW'(1)) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_count_d = err_count_q;
    err_vld_d   = err_vld_q;
    err_addr_d  = err_addr_q;
    if (err_clear) begin
      err_count_d = '0;
      err_vld_d   = 1'b0;
      err_addr_d  = '0;
    end else if (done) begin
      if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
      if (!err_vld_q) begin
        err_vld_d  = 1'b1;
        err_addr_d = hdr_q.addr;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_count_q <= '0;
      err_vld_q   <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_count_q <= err_count_d;
      err_vld_q   <= err_vld_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // Queue storage and latched header carry no reset; validity comes from control state.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= entry_in;
    hdr_q   <= hdr_d;
    beats_q <= beats_d;
  end

  assign tl.a_ready   = !full;
  assign tl.d_valid   = (state_q == RESP);
  assign tl.d_opcode  = resp_opcode(hdr_q.op);
  assign tl.d_param   = 2'd0;
  assign tl.d_size    = hdr_q.size;
  assign tl.d_source  = hdr_q.src;
  assign tl.d_sink    = 1'b0;
  assign tl.d_denied  = tl.d_valid;
  assign tl.d_data    = '0;
  assign tl.d_corrupt = tl.d_valid && (resp_opcode(hdr_q.op) == 3'd1);

  assign err_count = err_count_q;
  assign err_vld   = err_vld_q;
  assign err_addr  = err_addr_q;
endmodule

// File: tb/tb_tl_error_slave_q.sv
// Directed bench for tl_error_slave_q: inputs and samples on the falling edge,
// DUT state advances on the rising edge in between.
module tb_tl_error_slave_q;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 14;
  localparam int SRC_W  = 3;
  localparam int SIZE_W = 4;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic err_clear = 1'b0;
  logic [CNT_W-1:0]  err_count;
  logic              err_vld;
  logic [ADDR_W-1:0] err_addr;
  int checks = 0;
  int errors = 0;

  tl_error_slave_q_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SRC_W(SRC_W),
                        .SIZE_W(SIZE_W)) tl ();

  tl_error_slave_q #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SRC_W(SRC_W),
                     .SIZE_W(SIZE_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clk), .reset_n(reset_n), .tl(tl), .err_clear(err_clear),
    .err_count(err_count), .err_vld(err_vld), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // Called on a falling edge; returns on the falling edge after the handshake.
  task automatic send_a(input logic [2:0] op, input logic [3:0] size,
                        input logic [2:0] src, input logic [13:0] addr);
    int t = 0;
    tl.a_valid = 1'b1; tl.a_opcode = op; tl.a_size = size;
    tl.a_source = src; tl.a_address = addr; tl.a_data = 32'hDEAD_BEEF;
    while (!tl.a_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin
      checks++; errors++;
      $display("FAIL a_handshake timeout: a_ready=%0b required 1", tl.a_ready);
    end
    @(negedge clk);
    tl.a_valid = 1'b0;
  endtask

  task automatic recv_d(output logic ok, output logic [2:0] op,
                        output logic [2:0] src, output logic corrupt);
    int t = 0;
    tl.d_ready = 1'b1;
    while (!tl.d_valid && t < 200) begin @(negedge clk); t++; end
    ok = tl.d_valid; op = tl.d_opcode; src = tl.d_source; corrupt = tl.d_corrupt;
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tl.d_valid !== 1'b0 || tl.a_ready !== 1'b1) begin errors++;
      $display("FAIL reset_hs: d_valid=%0b a_ready=%0b required 0/1", tl.d_valid, tl.a_ready); end
    checks++;
    if (err_count !== 3'd0 || err_vld !== 1'b0 || err_addr !== 14'd0) begin errors++;
      $display("FAIL reset_log: cnt=%0d vld=%0b addr=%h required 0/0/0", err_count, err_vld, err_addr); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_get_latency();
    tl.d_ready = 1'b1;
    send_a(3'd4, 4'd2, 3'd5, 14'h100);
    checks++;
    if (tl.d_valid !== 1'b0) begin errors++;
      $display("FAIL latency_n1: d_valid=%0b required 0", tl.d_valid); end
    @(negedge clk);
    checks++;
    if (tl.d_valid !== 1'b1 || tl.d_opcode !== 3'd1 || tl.d_denied !== 1'b1 ||
        tl.d_corrupt !== 1'b1 || tl.d_data !== 32'd0 || tl.d_source !== 3'd5 ||
        tl.d_size !== 4'd2 || tl.d_param !== 2'd0 || tl.d_sink !== 1'b0) begin errors++;
      $display("FAIL get_beat: v=%0b op=%0d den=%0b cor=%0b data=%h src=%0d size=%0d required 1/1/1/1/0/5/2",
               tl.d_valid, tl.d_opcode, tl.d_denied, tl.d_corrupt, tl.d_data, tl.d_source, tl.d_size); end
    @(negedge clk);
    checks++;
    if (tl.d_valid !== 1'b0) begin errors++;
      $display("FAIL get_single_beat: d_valid=%0b required 0", tl.d_valid); end
    checks++;
    if (err_count !== 3'd1 || err_vld !== 1'b1 || err_addr !== 14'h100) begin errors++;
      $display("FAIL get_log: cnt=%0d vld=%0b addr=%h required 1/1/100", err_count, err_vld, err_addr); end
  endtask

  task automatic test_put_burst();
    logic ok, cor; logic [2:0] op, src; int extra = 0;
    for (int i = 0; i < 4; i++) send_a(3'd0, 4'd4, 3'd2, 14'h40 + 14'(4 * i));
    recv_d(ok, op, src, cor);
    checks++;
    if (ok !== 1'b1 || op !== 3'd0 || cor !== 1'b0 || src !== 3'd2) begin errors++;
      $display("FAIL put_ack: ok=%0b op=%0d cor=%0b src=%0d required 1/0/0/2", ok, op, cor, src); end
    repeat (6) begin if (tl.d_valid) extra++; @(negedge clk); end
    checks++;
    if (extra != 0) begin errors++;
      $display("FAIL put_single_ack: extra beats=%0d required 0", extra); end
  endtask

  task automatic test_arith_and_illegal();
    logic ok, cor; logic [2:0] op, src; int extra = 0;
    send_a(3'd2, 4'd3, 3'd3, 14'h60);
    send_a(3'd2, 4'd3, 3'd3, 14'h64);
    for (int b = 0; b < 2; b++) begin
      recv_d(ok, op, src, cor);
      checks++;
      if (ok !== 1'b1 || op !== 3'd1 || cor !== 1'b1 || src !== 3'd3) begin errors++;
        $display("FAIL arith_beat%0d: ok=%0b op=%0d cor=%0b src=%0d required 1/1/1/3", b, ok, op, cor, src); end
    end
    send_a(3'd7, 4'd5, 3'd4, 14'h70);
    recv_d(ok, op, src, cor);
    checks++;
    if (ok !== 1'b1 || op !== 3'd0 || cor !== 1'b0 || src !== 3'd4) begin errors++;
      $display("FAIL illegal_ack: ok=%0b op=%0d cor=%0b src=%0d required 1/0/0/4", ok, op, cor, src); end
    repeat (4) begin if (tl.d_valid) extra++; @(negedge clk); end
    checks++;
    if (extra != 0) begin errors++;
      $display("FAIL arith_beats: extra beats=%0d required 0", extra); end
  endtask

  task automatic test_stall_burst();
    logic [2:0] op0, src0; logic [3:0] sz0; int beats = 0; int t = 0; int unstable = 0;
    tl.d_ready = 1'b0;
    send_a(3'd4, 4'd5, 3'd3, 14'h180);
    while (!tl.d_valid && t < 50) begin @(negedge clk); t++; end
    for (int b = 0; b < 8; b++) begin
      op0 = tl.d_opcode; src0 = tl.d_source; sz0 = tl.d_size;
      @(negedge clk);
      if (!tl.d_valid || tl.d_opcode !== op0 || tl.d_source !== src0 ||
          tl.d_size !== sz0 || op0 !== 3'd1 || src0 !== 3'd3 || sz0 !== 4'd5) unstable++;
      tl.d_ready = 1'b1;
      if (tl.d_valid) beats++;
      @(negedge clk);
      tl.d_ready = 1'b0;
    end
    checks++;
    if (beats != 8 || unstable != 0) begin errors++;
      $display("FAIL stall_burst: beats=%0d unstable=%0d required 8/0", beats, unstable); end
    checks++;
    if (tl.d_valid !== 1'b0) begin errors++;
      $display("FAIL stall_idle: d_valid=%0b required 0", tl.d_valid); end
    tl.d_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic ok, cor; logic [2:0] op; logic [2:0] srcs [4]; int held = 0;
    tl.d_ready = 1'b0;
    // First Get moves into the FSM, the next two occupy both queue entries.
    send_a(3'd4, 4'd2, 3'd1, 14'h10);
    send_a(3'd4, 4'd2, 3'd2, 14'h14);
    send_a(3'd4, 4'd2, 3'd3, 14'h18);
    checks++;
    if (tl.a_ready !== 1'b0) begin errors++;
      $display("FAIL queue_full: a_ready=%0b required 0", tl.a_ready); end
    tl.a_valid = 1'b1; tl.a_opcode = 3'd4; tl.a_size = 4'd2;
    tl.a_source = 3'd4; tl.a_address = 14'h1C;
    repeat (5) begin @(negedge clk); if (tl.a_ready) held++; end
    checks++;
    if (held != 0) begin errors++;
      $display("FAIL queue_hold: a_ready high %0d cycles required 0", held); end
    fork
      begin
        int t = 0;
        while (!tl.a_ready && t < 100) begin @(negedge clk); t++; end
        @(negedge clk);
        tl.a_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 4; i++) recv_d(ok, op, srcs[i], cor);
      end
    join
    checks++;
    if (srcs[0] !== 3'd1 || srcs[1] !== 3'd2 || srcs[2] !== 3'd3 || srcs[3] !== 3'd4) begin errors++;
      $display("FAIL order: srcs=%0d,%0d,%0d,%0d required 1,2,3,4", srcs[0], srcs[1], srcs[2], srcs[3]); end
  endtask

  task automatic test_intent_log();
    logic ok, cor; logic [2:0] op, src;
    pulse_clear();
    checks++;
    if (err_count !== 3'd0 || err_vld !== 1'b0 || err_addr !== 14'd0) begin errors++;
      $display("FAIL clear: cnt=%0d vld=%0b addr=%h required 0/0/0", err_count, err_vld, err_addr); end
    send_a(3'd5, 4'd2, 3'd1, 14'h80);
    recv_d(ok, op, src, cor);
    checks++;
    if (ok !== 1'b1 || op !== 3'd2 || cor !== 1'b0 || src !== 3'd1) begin errors++;
      $display("FAIL hintack: ok=%0b op=%0d cor=%0b src=%0d required 1/2/0/1", ok, op, cor, src); end
    send_a(3'd4, 4'd2, 3'd2, 14'h200);
    recv_d(ok, op, src, cor);
    checks++;
    if (ok !== 1'b1 || op !== 3'd1 || cor !== 1'b1 || src !== 3'd2) begin errors++;
      $display("FAIL intent_get: ok=%0b op=%0d cor=%0b src=%0d required 1/1/1/2", ok, op, cor, src); end
    checks++;
    if (err_count !== 3'd2 || err_vld !== 1'b1 || err_addr !== 14'h80) begin errors++;
      $display("FAIL intent_log: cnt=%0d vld=%0b addr=%h required 2/1/080", err_count, err_vld, err_addr); end
  endtask

  task automatic test_saturation();
    logic ok, cor; logic [2:0] op, src;
    pulse_clear();
    for (int i = 0; i < 7; i++) begin
      send_a(3'd4, 4'd2, 3'(i), 14'h300 + 14'(4 * i));
      recv_d(ok, op, src, cor);
    end
    checks++;
    if (err_count !== 3'd7 || err_addr !== 14'h300) begin errors++;
      $display("FAIL sat_reach: cnt=%0d addr=%h required 7/300", err_count, err_addr); end
    send_a(3'd4, 4'd2, 3'd0, 14'h3F0);
    recv_d(ok, op, src, cor);
    checks++;
    if (err_count !== 3'd7) begin errors++;
      $display("FAIL sat_hold: cnt=%0d required 7", err_count); end
  endtask

  task automatic test_clear_collide();
    int t = 0;
    tl.d_ready = 1'b0;
    send_a(3'd4, 4'd2, 3'd6, 14'h120);
    while (!tl.d_valid && t < 50) begin @(negedge clk); t++; end
    tl.d_ready = 1'b1; err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    checks++;
    if (err_count !== 3'd0 || err_vld !== 1'b0 || err_addr !== 14'd0 || tl.d_valid !== 1'b0) begin errors++;
      $display("FAIL clear_collide: cnt=%0d vld=%0b addr=%h d_valid=%0b required 0/0/0/0",
               err_count, err_vld, err_addr, tl.d_valid); end
  endtask

  task automatic test_reset_abort();
    int t = 0; int stray = 0;
    tl.d_ready = 1'b0;
    send_a(3'd4, 4'd5, 3'd6, 14'h240);
    while (!tl.d_valid && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (tl.d_valid !== 1'b1) begin errors++;
      $display("FAIL abort_start: d_valid=%0b required 1", tl.d_valid); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (tl.d_valid !== 1'b0 || tl.a_ready !== 1'b1) begin errors++;
      $display("FAIL abort_async: d_valid=%0b a_ready=%0b required 0/1", tl.d_valid, tl.a_ready); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tl.d_ready = 1'b1;
    repeat (6) begin @(negedge clk); if (tl.d_valid) stray++; end
    checks++;
    if (stray != 0 || err_count !== 3'd0) begin errors++;
      $display("FAIL abort_quiet: stray beats=%0d cnt=%0d required 0/0", stray, err_count); end
  endtask

  initial begin
    tl.a_valid = 1'b0; tl.a_opcode = 3'd0; tl.a_param = 3'd0; tl.a_size = 4'd0;
    tl.a_source = 3'd0; tl.a_address = 14'd0; tl.a_mask = 4'hF; tl.a_data = 32'd0;
    tl.a_corrupt = 1'b0; tl.d_ready = 1'b0;
    #2;
    test_reset();
    test_get_latency();
    test_put_burst();
    test_arith_and_illegal();
    test_stall_burst();
    test_back_to_back();
    test_intent_log();
    test_saturation();
    test_clear_collide();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
